// File: rtl/fetch_front_pkg.sv
// fetch_front_pkg: shared fetch types; write codes WR_STREAM/WR_FLUSH (1x = keep), fetch_data_t, fetch_state_t, ibus request/response structs
package fetch_front_pkg;
  localparam logic [1:0] WR_STREAM = 2'b00;
  localparam logic [1:0] WR_FLUSH = 2'b01;
  typedef struct packed {
    logic valid;
    logic [63:0] pc;
    logic [31:0] raw_instr;
  } fetch_data_t;
  typedef enum logic [1:0] {IDLE, BUSY, DROP} fetch_state_t;
  typedef struct packed {
    logic valid;
    logic [63:0] addr;
  } ibus_req_t;
  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

// File: rtl/fetch_front_if.sv
// fetch_front_if: instruction bus; ireq {valid, addr} from the fetch master, iresp {addr_ok, data_ok, data} from memory
interface fetch_front_if;
  import fetch_front_pkg::*;
  ibus_req_t ireq;
  ibus_resp_t iresp;
  modport master(output ireq, input iresp);
  modport slave(input ireq, output iresp);
endinterface

// File: rtl/fetch_front_pipe_reg.sv
// pipe_reg: stream/flush/keep pipeline register; ports clk, reset, wr (00 load d, 01 clear valid, 1x hold), d, q
module pipe_reg
  import fetch_front_pkg::*;
#(
  parameter type T = fetch_data_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] wr,
  input  T           d,
  output T           q
);
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else if (wr == WR_STREAM) q <= d;
    else if (wr == WR_FLUSH) q.valid <= 1'b0;
endmodule

// File: rtl/fetch_front.sv
// fetch_front: PC, ibus fetch FSM, one-entry buffer, F/D registers; in clk reset pc_sel pc_target pc_write f_write d_write, ibus master, out dvalid dpc dinstr fetch_busy
module fetch_front
  import fetch_front_pkg::*;
#(
  parameter logic [63:0] PCINIT = 64'h8000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pc_sel,
  input  logic [63:0]          pc_target,
  input  logic [1:0]           pc_write,
  input  logic [1:0]           f_write,
  input  logic [1:0]           d_write,
  fetch_front_if.master        ibus,
  output logic                 dvalid,
  output logic [63:0]          dpc,
  output logic [31:0]          dinstr,
  output logic                 fetch_busy
);
  fetch_state_t state;
  logic [63:0] pc, req_addr;
  fetch_data_t fbuf, fq, fd, dq, deliv;
  logic redir, issue, deliver, bypass;
  always_comb begin
    redir = pc_sel && pc_write == WR_STREAM;
    issue = state == IDLE && !redir && pc_write == WR_STREAM && !fbuf.valid;
    deliver = state == BUSY && ibus.iresp.data_ok && !redir;
    bypass = deliver && f_write == WR_STREAM && !fbuf.valid;
    deliv = fetch_data_t'{valid: 1'b1, pc: req_addr, raw_instr: ibus.iresp.data};
    fd = fbuf.valid ? fbuf : bypass ? deliv : fetch_data_t'{valid: 1'b0, pc: fq.pc, raw_instr: fq.raw_instr};
    ibus.ireq = ibus_req_t'{valid: state != IDLE, addr: req_addr};
    fetch_busy = state != IDLE;
    dvalid = dq.valid;
    dpc = dq.pc;
    dinstr = dq.raw_instr;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      pc <= PCINIT;
      req_addr <= '0;
      fbuf <= '0;
    end else begin
      pc <= redir ? pc_target : issue ? pc + 64'd4 : pc;
      if (issue) req_addr <= pc;
      if (redir) fbuf.valid <= 1'b0;
      else if (deliver && !bypass) fbuf <= deliv;
      else if (f_write == WR_STREAM) fbuf.valid <= 1'b0;
      state <= state == IDLE ? (issue ? BUSY : IDLE)
             : ibus.iresp.data_ok ? IDLE
             : (state == BUSY && redir) ? DROP : state;
    end
  pipe_reg #(.T(fetch_data_t)) f_reg (.clk(clk), .reset(reset), .wr(f_write), .d(fd), .q(fq));
  pipe_reg #(.T(fetch_data_t)) d_reg (.clk(clk), .reset(reset), .wr(d_write), .d(fq), .q(dq));
endmodule

// File: tb/tb_fetch_front.sv
// tb_fetch_front: directed self-checking bench for fetch_front
module tb_fetch_front;
  import fetch_front_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pc_sel = 1'b0;
  logic [63:0] pc_target = '0;
  logic [1:0] pc_write = 2'b00, f_write = 2'b00, d_write = 2'b00;
  logic dvalid, fetch_busy;
  logic [63:0] dpc;
  logic [31:0] dinstr;
  int total = 0, bad = 0;
  fetch_front_if bus();
  fetch_front dut (
    .clk(clk), .reset(reset), .pc_sel(pc_sel), .pc_target(pc_target),
    .pc_write(pc_write), .f_write(f_write), .d_write(d_write), .ibus(bus),
    .dvalid(dvalid), .dpc(dpc), .dinstr(dinstr), .fetch_busy(fetch_busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic resp(input logic ok, input logic [31:0] d);
    bus.iresp = ibus_resp_t'{addr_ok: 1'b0, data_ok: ok, data: d};
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  initial begin
    resp(1'b0, '0);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", 64'(bus.ireq.valid), 64'd0);
    chk("rst_busy", 64'(fetch_busy), 64'd0);
    chk("rst_dvalid", 64'(dvalid), 64'd0);
    chk("rst_dpc", dpc, 64'd0);
    chk("rst_dinstr", 64'(dinstr), 64'd0);
    tick();
    chk("t1_valid0", 64'(bus.ireq.valid), 64'd1);
    chk("t1_addr0", bus.ireq.addr, 64'h8000_0000);
    chk("t1_busy0", 64'(fetch_busy), 64'd1);
    resp(1'b1, 32'h0000_0013);
    tick();
    resp(1'b0, '0);
    chk("t1_idle", 64'(bus.ireq.valid), 64'd0);
    chk("t1_dv_early", 64'(dvalid), 64'd0);
    tick();
    chk("t1_addr1", bus.ireq.addr, 64'h8000_0004);
    chk("t1_valid1", 64'(bus.ireq.valid), 64'd1);
    chk("t1_dvalid0", 64'(dvalid), 64'd1);
    chk("t1_dpc0", dpc, 64'h8000_0000);
    chk("t1_dinstr0", 64'(dinstr), 64'h0000_0013);
    resp(1'b1, 32'h0010_0093);
    tick();
    resp(1'b0, '0);
    chk("t1_dv_gap", 64'(dvalid), 64'd0);
    tick();
    chk("t1_dvalid1", 64'(dvalid), 64'd1);
    chk("t1_dpc1", dpc, 64'h8000_0004);
    chk("t1_dinstr1", 64'(dinstr), 64'h0010_0093);
    chk("t1_addr2", bus.ireq.addr, 64'h8000_0008);
    pc_sel = 1'b1;
    pc_target = 64'h8000_0100;
    tick();
    pc_sel = 1'b0;
    chk("t2_drop_busy", 64'(fetch_busy), 64'd1);
    chk("t2_drop_addr", bus.ireq.addr, 64'h8000_0008);
    resp(1'b1, 32'hdead_beef);
    tick();
    resp(1'b0, '0);
    chk("t2_idle", 64'(bus.ireq.valid), 64'd0);
    chk("t2_no_stale", 64'(dvalid), 64'd0);
    tick();
    chk("t2_addr", bus.ireq.addr, 64'h8000_0100);
    chk("t2_valid", 64'(bus.ireq.valid), 64'd1);
    chk("t2_no_stale2", 64'(dvalid), 64'd0);
    resp(1'b1, 32'h0020_0113);
    tick();
    resp(1'b0, '0);
    tick();
    chk("t2_dvalid", 64'(dvalid), 64'd1);
    chk("t2_dpc", dpc, 64'h8000_0100);
    chk("t2_dinstr", 64'(dinstr), 64'h0020_0113);
    f_write = 2'b11;
    d_write = 2'b01;
    resp(1'b1, 32'h0030_0193);
    tick();
    resp(1'b0, '0);
    chk("t3_dv_a", 64'(dvalid), 64'd0);
    chk("t3_busy", 64'(fetch_busy), 64'd0);
    tick();
    chk("t3_dv_b", 64'(dvalid), 64'd0);
    chk("t3_no_issue", 64'(bus.ireq.valid), 64'd0);
    tick();
    chk("t3_dv_c", 64'(dvalid), 64'd0);
    f_write = 2'b00;
    d_write = 2'b00;
    tick();
    chk("t3_dv_d", 64'(dvalid), 64'd0);
    chk("t3_no_issue2", 64'(bus.ireq.valid), 64'd0);
    tick();
    chk("t3_dvalid", 64'(dvalid), 64'd1);
    chk("t3_dpc", dpc, 64'h8000_0104);
    chk("t3_dinstr", 64'(dinstr), 64'h0030_0193);
    chk("t3_addr", bus.ireq.addr, 64'h8000_0108);
    pc_sel = 1'b1;
    pc_target = 64'h8000_0200;
    resp(1'b1, 32'hbad0_bad0);
    tick();
    pc_sel = 1'b0;
    resp(1'b0, '0);
    chk("t4_valid", 64'(bus.ireq.valid), 64'd0);
    chk("t4_busy", 64'(fetch_busy), 64'd0);
    chk("t4_dvalid", 64'(dvalid), 64'd0);
    tick();
    chk("t4_addr", bus.ireq.addr, 64'h8000_0200);
    chk("t4_dvalid2", 64'(dvalid), 64'd0);
    resp(1'b1, 32'h0040_0213);
    tick();
    resp(1'b0, '0);
    tick();
    chk("t4_dpc", dpc, 64'h8000_0200);
    chk("t4_dinstr", 64'(dinstr), 64'h0040_0213);
    chk("t4_busy2", 64'(fetch_busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_valid", 64'(bus.ireq.valid), 64'd0);
    chk("t5_busy", 64'(fetch_busy), 64'd0);
    chk("t5_dvalid", 64'(dvalid), 64'd0);
    pc_write = 2'b11;
    resp(1'b1, 32'h1111_1111);
    tick();
    chk("t5_ignore_valid", 64'(bus.ireq.valid), 64'd0);
    tick();
    chk("t5_ignore_dv", 64'(dvalid), 64'd0);
    pc_write = 2'b00;
    resp(1'b0, '0);
    tick();
    chk("t5_pcinit", bus.ireq.addr, 64'h8000_0000);
    resp(1'b1, 32'h0050_0293);
    tick();
    resp(1'b0, '0);
    tick();
    chk("t5_dpc", dpc, 64'h8000_0000);
    chk("t5_dinstr", 64'(dinstr), 64'h0050_0293);
    pc_sel = 1'b1;
    pc_target = 64'hffff_ffff_ffff_fffc;
    resp(1'b1, 32'h2222_2222);
    tick();
    pc_sel = 1'b0;
    resp(1'b0, '0);
    tick();
    chk("t6_addr_top", bus.ireq.addr, 64'hffff_ffff_ffff_fffc);
    resp(1'b1, 32'h0060_0313);
    tick();
    resp(1'b0, '0);
    tick();
    chk("t6_addr_wrap", bus.ireq.addr, 64'd0);
    chk("t6_dvalid", 64'(dvalid), 64'd1);
    chk("t6_dpc", dpc, 64'hffff_ffff_ffff_fffc);
    chk("t6_dinstr", 64'(dinstr), 64'h0060_0313);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
